// File: rtl/turn_signal_ctrl_pkg.sv
// Shared definitions for the turn-signal controller and the tail-light sequencer bench.
package turn_signal_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LEFT   = 2'd1,
        RIGHT  = 2'd2,
        HAZARD = 2'd3
    } state_t;

    localparam int unsigned DEB_CYCLES_DEF = 4;
    localparam int unsigned MIN_HOLD_DEF   = 8;

endpackage

// File: rtl/input_debounce.sv
// Two-flop synchronizer followed by a consecutive-cycle debounce counter.
module input_debounce
    import turn_signal_ctrl_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    logic       sync1;
    logic       sync2;
    logic [7:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            dout  <= 1'b0;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
            // Any agreeing cycle restarts the count, so only an unbroken run updates dout.
            if (sync2 == dout) begin
                cnt <= '0;
            end else if (cnt == 8'(DEB_CYCLES - 1)) begin
                dout <= sync2;
                cnt  <= '0;
            end else begin
                cnt <= cnt + 8'd1;
            end
        end
    end

endmodule

// File: rtl/turn_signal_ctrl.sv
// Turn-signal request FSM: debounced stalk/hazard inputs drive lt/rt/haz with a minimum hold.
module turn_signal_ctrl
    import turn_signal_ctrl_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF,
    parameter int unsigned MIN_HOLD   = MIN_HOLD_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic lever_l,
    input  logic lever_r,
    input  logic haz_btn,
    output logic lt,
    output logic rt,
    output logic haz
);

    localparam logic [7:0] HOLD_LOAD = 8'(MIN_HOLD - 1);

    logic   deb_l;
    logic   deb_r;
    logic   deb_haz;
    logic   haz_prev;
    logic   haz_press;
    state_t state;
    state_t nxt;
    logic [7:0] hold;
    logic [7:0] hold_nxt;

    input_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_l (
        .clk (clk),
        .rst (rst),
        .din (lever_l),
        .dout(deb_l)
    );

    input_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_r (
        .clk (clk),
        .rst (rst),
        .din (lever_r),
        .dout(deb_r)
    );

    input_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_haz (
        .clk (clk),
        .rst (rst),
        .din (haz_btn),
        .dout(deb_haz)
    );

    assign haz_press = deb_haz & ~haz_prev;

    always_comb begin
        nxt      = state;
        hold_nxt = hold;
        unique case (state)
            IDLE: begin
                if (haz_press) begin
                    nxt = HAZARD;
                end else if (deb_l && !deb_r) begin
                    nxt      = LEFT;
                    hold_nxt = HOLD_LOAD;
                end else if (deb_r && !deb_l) begin
                    nxt      = RIGHT;
                    hold_nxt = HOLD_LOAD;
                end
            end
            LEFT, RIGHT: begin
                if (haz_press) begin
                    nxt = HAZARD;
                end else if (hold != '0) begin
                    hold_nxt = hold - 8'd1;
                end else if ((state == LEFT) ? deb_l : deb_r) begin
                    nxt = state;
                end else if ((state == LEFT) ? (deb_r && !deb_l) : (deb_l && !deb_r)) begin
                    nxt      = (state == LEFT) ? RIGHT : LEFT;
                    hold_nxt = HOLD_LOAD;
                end else begin
                    nxt = IDLE;
                end
            end
            HAZARD: begin
                if (haz_press) begin
                    nxt = IDLE;
                end
            end
            default: nxt = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they always equal a decode of state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            hold     <= '0;
            haz_prev <= 1'b0;
            lt       <= 1'b0;
            rt       <= 1'b0;
            haz      <= 1'b0;
        end else begin
            state    <= nxt;
            hold     <= hold_nxt;
            haz_prev <= deb_haz;
            lt       <= (nxt == LEFT);
            rt       <= (nxt == RIGHT);
            haz      <= (nxt == HAZARD);
        end
    end

endmodule

// File: tb/tb_turn_signal_ctrl.sv
// Directed self-checking bench for turn_signal_ctrl at default parameters.
module tb_turn_signal_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic lever_l = 1'b0;
    logic lever_r = 1'b0;
    logic haz_btn = 1'b0;
    logic lt;
    logic rt;
    logic haz;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    turn_signal_ctrl #(.DEB_CYCLES(4), .MIN_HOLD(8)) dut (
        .clk    (clk),
        .rst    (rst),
        .lever_l(lever_l),
        .lever_r(lever_r),
        .haz_btn(haz_btn),
        .lt     (lt),
        .rt     (rt),
        .haz    (haz)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick(input int unsigned n = 1);
        for (int unsigned i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick(2);
        n_checks++;
        if ({lt, rt, haz} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_outputs: got lt/rt/haz=%b expected 000", {lt, rt, haz});
        end
        rst = 1'b0;
        tick(10);
        n_checks++;
        if ({lt, rt, haz} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_idle: got lt/rt/haz=%b expected 000", {lt, rt, haz});
        end
    endtask

    task automatic test_left_hold;
        lever_l = 1'b1;
        for (int unsigned i = 1; i <= 7; i++) begin
            tick();
            n_checks++;
            if ({lt, rt, haz} !== ((i == 7) ? 3'b100 : 3'b000)) begin
                n_fail++;
                $display("FAIL left_latency edge+%0d: got lt/rt/haz=%b expected %b",
                         i, {lt, rt, haz}, (i == 7) ? 3'b100 : 3'b000);
            end
        end
        lever_l = 1'b0;
        for (int unsigned i = 1; i <= 8; i++) begin
            tick();
            n_checks++;
            if ({lt, rt, haz} !== ((i <= 7) ? 3'b100 : 3'b000)) begin
                n_fail++;
                $display("FAIL left_min_hold cycle %0d: got lt/rt/haz=%b expected %b",
                         i, {lt, rt, haz}, (i <= 7) ? 3'b100 : 3'b000);
            end
        end
        tick(10);
    endtask

    task automatic test_glitch;
        lever_r = 1'b1;
        tick(3);
        lever_r = 1'b0;
        for (int unsigned i = 1; i <= 15; i++) begin
            tick();
            n_checks++;
            if ({lt, rt, haz} !== 3'b000) begin
                n_fail++;
                $display("FAIL glitch_rejected cycle %0d: got lt/rt/haz=%b expected 000", i, {lt, rt, haz});
            end
        end
    endtask

    task automatic test_both_levers;
        lever_l = 1'b1;
        lever_r = 1'b1;
        for (int unsigned i = 1; i <= 20; i++) begin
            tick();
            n_checks++;
            if ({lt, rt, haz} !== 3'b000) begin
                n_fail++;
                $display("FAIL both_levers cycle %0d: got lt/rt/haz=%b expected 000", i, {lt, rt, haz});
            end
        end
        lever_l = 1'b0;
        lever_r = 1'b0;
        tick(10);
    endtask

    task automatic test_hazard_override;
        lever_l = 1'b1;
        tick(7);
        n_checks++;
        if ({lt, rt, haz} !== 3'b100) begin
            n_fail++;
            $display("FAIL haz_pre_left: got lt/rt/haz=%b expected 100", {lt, rt, haz});
        end
        tick(3);
        haz_btn = 1'b1;
        tick(6);
        haz_btn = 1'b0;
        n_checks++;
        if ({lt, rt, haz} !== 3'b100) begin
            n_fail++;
            $display("FAIL haz_before_press: got lt/rt/haz=%b expected 100", {lt, rt, haz});
        end
        tick();
        n_checks++;
        if ({lt, rt, haz} !== 3'b001) begin
            n_fail++;
            $display("FAIL haz_enter: got lt/rt/haz=%b expected 001", {lt, rt, haz});
        end
        for (int unsigned i = 1; i <= 12; i++) begin
            tick();
            n_checks++;
            if ({lt, rt, haz} !== 3'b001) begin
                n_fail++;
                $display("FAIL haz_ignores_lever cycle %0d: got lt/rt/haz=%b expected 001", i, {lt, rt, haz});
            end
        end
        haz_btn = 1'b1;
        tick(6);
        haz_btn = 1'b0;
        tick();
        n_checks++;
        if ({lt, rt, haz} !== 3'b000) begin
            n_fail++;
            $display("FAIL haz_exit: got lt/rt/haz=%b expected 000", {lt, rt, haz});
        end
        tick();
        n_checks++;
        if ({lt, rt, haz} !== 3'b100) begin
            n_fail++;
            $display("FAIL haz_exit_relever: got lt/rt/haz=%b expected 100", {lt, rt, haz});
        end
        lever_l = 1'b0;
        tick(20);
    endtask

    task automatic test_back_to_back;
        lever_l = 1'b1;
        tick(7);
        n_checks++;
        if ({lt, rt, haz} !== 3'b100) begin
            n_fail++;
            $display("FAIL handover_left: got lt/rt/haz=%b expected 100", {lt, rt, haz});
        end
        lever_l = 1'b0;
        lever_r = 1'b1;
        for (int unsigned i = 1; i <= 8; i++) begin
            tick();
            n_checks++;
            if ({lt, rt, haz} !== ((i <= 7) ? 3'b100 : 3'b010)) begin
                n_fail++;
                $display("FAIL handover cycle %0d: got lt/rt/haz=%b expected %b",
                         i, {lt, rt, haz}, (i <= 7) ? 3'b100 : 3'b010);
            end
        end
        lever_r = 1'b0;
        tick(20);
        n_checks++;
        if ({lt, rt, haz} !== 3'b000) begin
            n_fail++;
            $display("FAIL handover_settle: got lt/rt/haz=%b expected 000", {lt, rt, haz});
        end
    endtask

    task automatic test_reset_in_hazard;
        haz_btn = 1'b1;
        tick(6);
        haz_btn = 1'b0;
        tick(4);
        n_checks++;
        if ({lt, rt, haz} !== 3'b001) begin
            n_fail++;
            $display("FAIL rst_haz_pre: got lt/rt/haz=%b expected 001", {lt, rt, haz});
        end
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({lt, rt, haz} !== 3'b000) begin
            n_fail++;
            $display("FAIL rst_async: got lt/rt/haz=%b expected 000", {lt, rt, haz});
        end
        tick(2);
        rst = 1'b0;
        for (int unsigned i = 1; i <= 12; i++) begin
            tick();
            n_checks++;
            if ({lt, rt, haz} !== 3'b000) begin
                n_fail++;
                $display("FAIL rst_haz_after cycle %0d: got lt/rt/haz=%b expected 000", i, {lt, rt, haz});
            end
        end
    endtask

    task automatic test_reset_held_button;
        haz_btn = 1'b1;
        tick(10);
        n_checks++;
        if (haz !== 1'b1) begin
            n_fail++;
            $display("FAIL held_btn_pre: got haz=%b expected 1", haz);
        end
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        for (int unsigned i = 1; i <= 7; i++) begin
            tick();
            n_checks++;
            if (haz !== ((i == 7) ? 1'b1 : 1'b0)) begin
                n_fail++;
                $display("FAIL held_btn_repress cycle %0d: got haz=%b expected %b",
                         i, haz, (i == 7) ? 1'b1 : 1'b0);
            end
        end
        haz_btn = 1'b0;
        tick(10);
        haz_btn = 1'b1;
        tick(6);
        haz_btn = 1'b0;
        tick();
        n_checks++;
        if ({lt, rt, haz} !== 3'b000) begin
            n_fail++;
            $display("FAIL held_btn_exit: got lt/rt/haz=%b expected 000", {lt, rt, haz});
        end
    endtask

    initial begin
        tick();
        test_reset();
        test_left_hold();
        test_glitch();
        test_both_levers();
        test_hazard_override();
        test_back_to_back();
        test_reset_in_hazard();
        test_reset_held_button();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
